// File: rtl/simd_lane_register.sv
// Multi-lane AES state register: masked parallel writes, beat-wise valid/ready
// load with a completion pulse, lane rotation and synchronous clear.

module simd_lane_cell #(
    parameter int LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr,
    input  logic [LANE_W-1:0] wr_d,
    input  logic              bw,
    input  logic [LANE_W-1:0] bw_d,
    input  logic              rot,
    input  logic [LANE_W-1:0] rot_d,
    output logic [LANE_W-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     q <= '0;
        else if (clr) q <= '0;
        else if (wr)  q <= wr_d;
        else if (bw)  q <= bw_d;
        else if (rot) q <= rot_d;
    end
endmodule

module simd_lane_register #(
    parameter int LANES      = 16,
    parameter int LANE_W     = 8,
    parameter int BEAT_LANES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic [LANES-1:0]             lane_mask,
    input  logic [LANES*LANE_W-1:0]      D,
    input  logic                         beat_valid,
    input  logic [BEAT_LANES*LANE_W-1:0] beat_data,
    output logic                         beat_ready,
    input  logic                         rot_en,
    output logic [LANES*LANE_W-1:0]      Q,
    output logic                         busy,
    output logic                         load_done
);
    localparam int BEATS = LANES / BEAT_LANES;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t  state, state_n;
    logic [KW-1:0] k, k_n;
    logic    done_n;
    logic    hs, rot_go;

    logic [LANES-1:0][LANE_W-1:0]      d_lanes, q_lanes;
    logic [BEAT_LANES-1:0][LANE_W-1:0] beat_lanes;

    assign d_lanes    = D;
    assign beat_lanes = beat_data;
    assign Q          = q_lanes;

    // Parallel write and clear both steal the bus, even with an empty mask.
    assign beat_ready = !clr && !en;
    assign hs         = beat_valid && beat_ready;
    assign rot_go     = rot_en && (state == IDLE) && !en && !clr && !hs;
    assign busy       = (state == LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            k         <= '0;
            load_done <= 1'b0;
        end else begin
            state     <= state_n;
            k         <= k_n;
            load_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        done_n  = 1'b0;
        if (clr) begin
            state_n = IDLE;
            k_n     = '0;
        end else if (hs) begin
            if (k == KW'(BEATS - 1)) begin
                state_n = IDLE;
                k_n     = '0;
                done_n  = 1'b1;
            end else begin
                state_n = LOAD;
                k_n     = k + KW'(1);
            end
        end
    end

    // Lane i belongs to beat i/BEAT_LANES; rotation pulls from lane i+1.
    for (genvar i = 0; i < LANES; i++) begin : gen_lane
        localparam int BI  = i / BEAT_LANES;
        localparam int BJ  = i % BEAT_LANES;
        localparam int NXT = (i + 1) % LANES;

        simd_lane_cell #(.LANE_W(LANE_W)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .wr    (en && lane_mask[i]),
            .wr_d  (d_lanes[i]),
            .bw    (hs && (k == KW'(BI))),
            .bw_d  (beat_lanes[BJ]),
            .rot   (rot_go),
            .rot_d (q_lanes[NXT]),
            .q     (q_lanes[i])
        );
    end
endmodule

// File: tb/tb_simd_lane_register.sv
// Self-checking bench for simd_lane_register: directed vector table, hand-written
// collision/abort sequences and randomized traffic against a lane-array model.

module tb_simd_lane_register;
    logic         clk = 1'b0;
    logic         rst, clr, en, beat_valid, rot_en;
    logic [15:0]  lane_mask;
    logic [127:0] D;
    logic [31:0]  beat_data;
    logic         beat_ready, busy, load_done;
    logic [127:0] Q;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 16 byte lanes, beat index, load flag, done flag.
    logic [7:0] m_lane [16];
    int         m_k;
    logic       m_busy, m_done;

    typedef struct {
        logic         en, clr, rot, bv;
        logic [15:0]  mask;
        logic [127:0] d;
        logic [31:0]  bd;
        logic [127:0] exp_q;
        logic         exp_busy, exp_done;
    } vec_t;
    vec_t tbl [11];

    simd_lane_register #(.LANES(16), .LANE_W(8), .BEAT_LANES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .en         (en),
        .lane_mask  (lane_mask),
        .D          (D),
        .beat_valid (beat_valid),
        .beat_data  (beat_data),
        .beat_ready (beat_ready),
        .rot_en     (rot_en),
        .Q          (Q),
        .busy       (busy),
        .load_done  (load_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] m_pack();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = m_lane[i];
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_lane[i] = 8'h00;
        m_k = 0; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic m_step();
        logic       hs;
        logic [7:0] first;
        hs     = beat_valid && !clr && !en;
        m_done = 1'b0;
        if (clr) begin
            m_reset();
        end else if (en) begin
            for (int i = 0; i < 16; i++) if (lane_mask[i]) m_lane[i] = D[i*8 +: 8];
        end else if (hs) begin
            for (int j = 0; j < 4; j++) m_lane[m_k*4 + j] = beat_data[j*8 +: 8];
            if (m_k == 3) begin
                m_k = 0; m_busy = 1'b0; m_done = 1'b1;
            end else begin
                m_k++; m_busy = 1'b1;
            end
        end else if (rot_en && !m_busy) begin
            first = m_lane[0];
            for (int i = 0; i < 15; i++) m_lane[i] = m_lane[i+1];
            m_lane[15] = first;
        end
    endtask

    // Inputs are already driven; check ready, advance model, clock, compare.
    task automatic cycle(input string nm);
        #1;
        chk({nm, ".ready"}, 128'(beat_ready), 128'(!clr && !en));
        m_step();
        @(posedge clk);
        #1;
        chk({nm, ".q"},    Q,               m_pack());
        chk({nm, ".busy"}, 128'(busy),      128'(m_busy));
        chk({nm, ".done"}, 128'(load_done), 128'(m_done));
    endtask

    task automatic idle_in();
        clr = 0; en = 0; lane_mask = '0; D = '0; beat_valid = 0; beat_data = '0; rot_en = 0;
    endtask

    task automatic beat(input logic [31:0] bd);
        idle_in(); beat_valid = 1; beat_data = bd;
        cycle("beat");
    endtask

    initial begin
        idle_in();
        rst = 0;
        m_reset();

        // Reset holds everything at zero regardless of en/D activity.
        for (int c = 0; c < 3; c++) begin
            en = ~en; lane_mask = 16'hFFFF; D = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            chk("rst.q", Q, 128'h0);
            chk("rst.busy", 128'(busy), 128'h0);
            chk("rst.done", 128'(load_done), 128'h0);
        end
        idle_in();
        rst = 1;
        cycle("hold");
        chk("hold.q0", Q, 128'h0);

        tbl[0]  = '{1, 0, 0, 0, 16'h00FF, {16{8'hAA}}, 32'h0,
                    128'h0000_0000_0000_0000_AAAA_AAAA_AAAA_AAAA, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 16'hFF00, {16{8'h55}}, 32'h0,
                    {{8{8'h55}}, {8{8'hAA}}}, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 16'h0, 128'h0, 32'h03020100,
                    128'h55555555_55555555_AAAAAAAA_03020100, 1, 0};
        tbl[3]  = '{0, 0, 0, 1, 16'h0, 128'h0, 32'h07060504,
                    128'h55555555_55555555_07060504_03020100, 1, 0};
        tbl[4]  = '{0, 0, 0, 0, 16'h0, 128'h0, 32'hFFFFFFFF,
                    128'h55555555_55555555_07060504_03020100, 1, 0};
        tbl[5]  = '{0, 0, 1, 0, 16'h0, 128'h0, 32'h0,
                    128'h55555555_55555555_07060504_03020100, 1, 0};
        tbl[6]  = '{0, 0, 0, 1, 16'h0, 128'h0, 32'h0B0A0908,
                    128'h55555555_0B0A0908_07060504_03020100, 1, 0};
        tbl[7]  = '{0, 0, 0, 1, 16'h0, 128'h0, 32'h0F0E0D0C,
                    128'h0F0E0D0C_0B0A0908_07060504_03020100, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 16'h0, 128'h0, 32'h0,
                    128'h0F0E0D0C_0B0A0908_07060504_03020100, 0, 0};
        tbl[9]  = '{0, 0, 1, 0, 16'h0, 128'h0, 32'h0,
                    128'h000F0E0D_0C0B0A09_08070605_04030201, 0, 0};
        tbl[10] = '{1, 0, 0, 1, 16'h0, {16{8'hEE}}, 32'hDEADBEEF,
                    128'h000F0E0D_0C0B0A09_08070605_04030201, 0, 0};

        foreach (tbl[i]) begin
            idle_in();
            en = tbl[i].en; clr = tbl[i].clr; rot_en = tbl[i].rot; beat_valid = tbl[i].bv;
            lane_mask = tbl[i].mask; D = tbl[i].d; beat_data = tbl[i].bd;
            cycle("vec");
            chk($sformatf("vec%0d.q", i), Q, tbl[i].exp_q);
            chk($sformatf("vec%0d.busy", i), 128'(busy), 128'(tbl[i].exp_busy));
            chk($sformatf("vec%0d.done", i), 128'(load_done), 128'(tbl[i].exp_done));
        end

        // Sixteen rotations come back to the starting value.
        for (int r = 0; r < 16; r++) begin
            idle_in(); rot_en = 1;
            cycle("rot16");
        end
        chk("rot16.wrap", Q, 128'h000F0E0D_0C0B0A09_08070605_04030201);

        // Parallel write colliding with a pending beat at k=2.
        idle_in(); clr = 1; cycle("clr");
        beat(32'h11111111);
        beat(32'h22222222);
        idle_in(); en = 1; lane_mask = 16'h0001; D = 128'hFF; beat_valid = 1; beat_data = 32'h99999999;
        cycle("coll");
        chk("coll.q", Q, 128'h00000000_00000000_22222222_111111FF);
        chk("coll.busy", 128'(busy), 128'h1);
        beat(32'h33333333);
        chk("coll.k2", Q, 128'h00000000_33333333_22222222_111111FF);
        beat(32'h44444444);
        chk("coll.final", Q, 128'h44444444_33333333_22222222_111111FF);
        chk("coll.done", 128'(load_done), 128'h1);

        // Clear at k=2 abandons the load without a done pulse.
        beat(32'hA1A1A1A1);
        beat(32'hB2B2B2B2);
        idle_in(); clr = 1; beat_valid = 1; beat_data = 32'hC3C3C3C3;
        cycle("abort");
        chk("abort.q", Q, 128'h0);
        chk("abort.busy", 128'(busy), 128'h0);
        idle_in(); cycle("abort2");
        chk("abort2.done", 128'(load_done), 128'h0);

        // Asynchronous reset mid-load, observed before the next clock edge.
        beat(32'hA1A1A1A1);
        beat(32'hB2B2B2B2);
        idle_in();
        #2 rst = 0;
        #1;
        chk("areset.q", Q, 128'h0);
        chk("areset.busy", 128'(busy), 128'h0);
        chk("areset.done", 128'(load_done), 128'h0);
        m_reset();
        @(posedge clk); #1;
        rst = 1;
        chk("areset.hold", 128'(load_done), 128'h0);

        beat(32'h03020100);
        beat(32'h07060504);
        beat(32'h0B0A0908);
        beat(32'h0F0E0D0C);
        chk("fresh.q", Q, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        chk("fresh.done", 128'(load_done), 128'h1);
        idle_in(); cycle("fresh.after");
        chk("fresh.pulse", 128'(load_done), 128'h0);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            clr        = ($urandom_range(15) == 0);
            en         = ($urandom_range(3) == 0);
            lane_mask  = 16'($urandom);
            D          = {$urandom, $urandom, $urandom, $urandom};
            beat_valid = $urandom_range(1);
            beat_data  = $urandom;
            rot_en     = ($urandom_range(3) == 0);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
